numlock_param_sm: RTL and testbench

Parametrised successor to the fixed 4-digit number-lock state machine. It accepts a CODE_LEN-digit binary code entered on two buttons (u = "1", z = "0"), with press-then-release per digit. It holds the lock open for a programmable number of cycles and counts failed attempts, entering a timed lockout after MAX_FAILS failures. It sits between the button aliases and the LED/SSD display logic of the board top, clocked by the divided system clock.

---
 rtl/numlock_param_sm.sv | 203 ++++++++++++++++++++
 tb/tb_numlock_param_sm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/numlock_param_sm.sv
// Parametrised press-then-release number lock with a timed open window and failed-attempt lockout.
// Define NUMLOCK_PROG_EN to add in-field reprogramming of the code (prog input, code_out output).
module numlock_param_sm #(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]   CODE           = 4'b1011,
  parameter int unsigned           OPEN_CYCLES    = 8,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 16
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                u,
  input  logic                z,
`ifdef NUMLOCK_PROG_EN
  input  logic                prog,
  output logic [CODE_LEN-1:0] code_out,
`endif
  output logic [2:0]          state,
  output logic [4:0]          digit_idx,
  output logic [3:0]          fail_cnt,
  output logic                unlock,
  output logic                bad,
  output logic                locked_out
);

  localparam int unsigned TimerMaxA = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TimerMax  = (TimerMaxA > 2) ? TimerMaxA : 2;
  localparam int unsigned TimerW    = $clog2(TimerMax);

  typedef enum logic [2:0] {
    StEntry   = 3'd0,
    StWaitRel = 3'd1,
    StOpening = 3'd2,
    StBad     = 3'd3,
    StLockout = 3'd4,
    StProg    = 3'd5,
    StProgRel = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          digit_idx_q, digit_idx_d;
  logic [3:0]          fail_cnt_q, fail_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                unlock_q, bad_q, locked_out_q;
  logic [CODE_LEN-1:0] code_reg;
  logic [CODE_LEN-1:0] code_shift;
  logic                exp_bit;
  logic                pressed, both, released;

`ifdef NUMLOCK_PROG_EN
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] sh_q, sh_d;
  assign code_reg = code_q;
  assign code_out = code_q;
`else
  assign code_reg = CODE;
`endif

  assign pressed  = u ^ z;
  assign both     = u & z;
  assign released = ~u & ~z;

  // Left-align the expected digit so the MSB of the shifted code is always the one to match.
  assign code_shift = code_reg << digit_idx_q;
  assign exp_bit    = code_shift[CODE_LEN-1];

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
`ifdef NUMLOCK_PROG_EN
    code_d      = code_q;
    sh_d        = sh_q;
`endif
    case (state_q)
      StEntry: begin
        if (both) begin
          state_d     = StBad;
          digit_idx_d = 5'd0;
        end else if (pressed) begin
          if (u == exp_bit) begin
            state_d     = StWaitRel;
            digit_idx_d = digit_idx_q + 5'd1;
          end else begin
            state_d     = StBad;
            digit_idx_d = 5'd0;
          end
        end
      end
      StWaitRel: begin
        if (released) begin
          if (digit_idx_q == 5'(CODE_LEN)) begin
            state_d     = StOpening;
            timer_d     = TimerW'(OPEN_CYCLES - 1);
            fail_cnt_d  = 4'd0;
            digit_idx_d = 5'd0;
          end else begin
            state_d = StEntry;
          end
        end
      end
      StOpening: begin
`ifdef NUMLOCK_PROG_EN
        if (prog) begin
          state_d     = StProg;
          digit_idx_d = 5'd0;
        end else
`endif
        if (timer_q == '0) begin
          state_d = StEntry;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StBad: begin
        digit_idx_d = 5'd0;
        if (released) begin
          if (({28'd0, fail_cnt_q} + 32'd1) == MAX_FAILS) begin
            state_d    = StLockout;
            timer_d    = TimerW'(LOCKOUT_CYCLES - 1);
            fail_cnt_d = 4'd0;
          end else begin
            state_d    = StEntry;
            fail_cnt_d = fail_cnt_q + 4'd1;
          end
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StEntry;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
`ifdef NUMLOCK_PROG_EN
      StProg: begin
        if (both) begin
          state_d     = StEntry;
          digit_idx_d = 5'd0;
        end else if (pressed) begin
          sh_d        = sh_q << 1;
          sh_d[0]     = u;
          digit_idx_d = digit_idx_q + 5'd1;
          state_d     = StProgRel;
        end
      end
      StProgRel: begin
        if (released) begin
          if (digit_idx_q == 5'(CODE_LEN)) begin
            code_d      = sh_q;
            digit_idx_d = 5'd0;
            state_d     = StEntry;
          end else begin
            state_d = StProg;
          end
        end
      end
`endif
      default: begin
        state_d     = StEntry;
        digit_idx_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= StEntry;
      digit_idx_q  <= 5'd0;
      fail_cnt_q   <= 4'd0;
      timer_q      <= '0;
      unlock_q     <= 1'b0;
      bad_q        <= 1'b0;
      locked_out_q <= 1'b0;
`ifdef NUMLOCK_PROG_EN
      code_q       <= CODE;
      sh_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      digit_idx_q  <= digit_idx_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      unlock_q     <= (state_d == StOpening);
      bad_q        <= (state_d == StBad);
      locked_out_q <= (state_d == StLockout);
`ifdef NUMLOCK_PROG_EN
      code_q       <= code_d;
      sh_q         <= sh_d;
`endif
    end
  end

  assign state      = state_q;
  assign digit_idx  = digit_idx_q;
  assign fail_cnt   = fail_cnt_q;
  assign unlock     = unlock_q;
  assign bad        = bad_q;
  assign locked_out = locked_out_q;

endmodule

// File: tb/tb_numlock_param_sm.sv
// Bench for numlock_param_sm: per-cycle comparison against a behavioural model plus
// hand-computed checkpoints. Define NUMLOCK_PROG_EN to also exercise code reprogramming.
module tb_numlock_param_sm;

  localparam int LEN   = 4;
  localparam int OPEN  = 8;
  localparam int MAXF  = 3;
  localparam int LOCK  = 16;

  localparam int M_E  = 0;
  localparam int M_W  = 1;
  localparam int M_O  = 2;
  localparam int M_B  = 3;
  localparam int M_L  = 4;
  localparam int M_P  = 5;
  localparam int M_PR = 6;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       u = 1'b0;
  logic       z = 1'b0;
  logic       prog = 1'b0;
  logic [2:0] state;
  logic [4:0] digit_idx;
  logic [3:0] fail_cnt;
  logic       unlock, bad, locked_out;
`ifdef NUMLOCK_PROG_EN
  logic [LEN-1:0] code_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  numlock_param_sm dut (
    .Clk        (Clk),
    .reset      (reset),
    .u          (u),
    .z          (z),
`ifdef NUMLOCK_PROG_EN
    .prog       (prog),
    .code_out   (code_out),
`endif
    .state      (state),
    .digit_idx  (digit_idx),
    .fail_cnt   (fail_cnt),
    .unlock     (unlock),
    .bad        (bad),
    .locked_out (locked_out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, digits matched, fails, cycles left in a timed mode.
  int             m_st = M_E;
  int             m_idx = 0;
  int             m_fail = 0;
  int             m_left = 0;
  logic [LEN-1:0] m_code = 4'b1011;
  logic [LEN-1:0] m_sh = '0;

  task automatic model_step();
    bit rel;
    rel = !u && !z;
    if (reset) begin
      m_st = M_E; m_idx = 0; m_fail = 0; m_left = 0; m_code = 4'b1011;
      return;
    end
    case (m_st)
      M_E: begin
        if (u && z) begin
          m_st = M_B; m_idx = 0;
        end else if (u != z) begin
          if (int'(u) == int'(m_code[LEN-1-m_idx])) begin
            m_idx++; m_st = M_W;
          end else begin
            m_st = M_B; m_idx = 0;
          end
        end
      end
      M_W: if (rel) begin
        if (m_idx == LEN) begin
          m_st = M_O; m_left = OPEN; m_fail = 0; m_idx = 0;
        end else m_st = M_E;
      end
      M_O: begin
`ifdef NUMLOCK_PROG_EN
        if (prog) begin
          m_st = M_P; m_idx = 0;
        end else
`endif
        if (m_left == 1) m_st = M_E;
        else m_left--;
      end
      M_B: begin
        m_idx = 0;
        if (rel) begin
          if (m_fail + 1 == MAXF) begin
            m_st = M_L; m_left = LOCK; m_fail = 0;
          end else begin
            m_fail++; m_st = M_E;
          end
        end
      end
      M_L: begin
        if (m_left == 1) m_st = M_E;
        else m_left--;
      end
      M_P: begin
        if (u && z) begin
          m_st = M_E; m_idx = 0;
        end else if (u != z) begin
          m_sh = {m_sh[LEN-2:0], u}; m_idx++; m_st = M_PR;
        end
      end
      M_PR: if (rel) begin
        if (m_idx == LEN) begin
          m_code = m_sh; m_idx = 0; m_st = M_E;
        end else m_st = M_P;
      end
      default: m_st = M_E;
    endcase
  endtask

  always begin
    @(posedge Clk);
    model_step();
    #1;
    check("state", state, m_st);
    check("digit_idx", digit_idx, m_idx);
    check("fail_cnt", fail_cnt, m_fail);
    check("unlock", unlock, m_st == M_O);
    check("bad", bad, m_st == M_B);
    check("locked_out", locked_out, m_st == M_L);
`ifdef NUMLOCK_PROG_EN
    check("code_out", code_out, m_code);
`endif
  end

  // Inputs change on the falling edge; returns after the consuming rising edge has settled.
  task automatic step(input logic uu, input logic zz, input logic rr = 1'b0,
                      input logic pp = 1'b0);
    @(negedge Clk);
    u = uu; z = zz; reset = rr; prog = pp;
    @(posedge Clk);
    #2;
  endtask

  task automatic enter(input logic [LEN-1:0] code);
    for (int i = LEN - 1; i >= 0; i--) begin
      step(code[i], ~code[i]);
      step(1'b0, 1'b0);
    end
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("rst_state", state, 0);
    check("rst_idx", digit_idx, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_flags", {unlock, bad, locked_out}, 0);

    // Correct 1011 with digit_idx stepping 1..4, then exactly eight open cycles
    step(1'b1, 1'b0); check("d1_idx", digit_idx, 1); check("d1_state", state, 1);
    step(1'b0, 1'b0); check("d1_rel", state, 0);
    step(1'b0, 1'b1); check("d2_idx", digit_idx, 2);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0); check("d3_idx", digit_idx, 3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0); check("d4_idx", digit_idx, 4);
    step(1'b0, 1'b0); check("open_first", unlock, 1); check("open_state", state, 2);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0); check("open_hold", unlock, 1);
    end
    step(1'b0, 1'b0); check("open_end", unlock, 0); check("open_end_state", state, 0);

    // 1,1: second digit wrong
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); check("bad_on", bad, 1); check("bad_idx", digit_idx, 0);
    step(1'b1, 1'b0); check("bad_held", bad, 1);
    step(1'b0, 1'b0); check("fail1", fail_cnt, 1); check("fail1_state", state, 0);

    // Two more wrong attempts; lockout lasts sixteen cycles with u held
    step(1'b0, 1'b1); step(1'b0, 1'b0); check("fail2", fail_cnt, 2);
    step(1'b0, 1'b1); check("bad3", bad, 1);
    step(1'b0, 1'b0); check("lock_first", locked_out, 1);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 1'b0); check("lock_hold", locked_out, 1); check("lock_state", state, 4);
    end
    step(1'b1, 1'b0); check("lock_end", locked_out, 0); check("lock_end_state", state, 0);
    check("lock_end_fail", fail_cnt, 0);
    step(1'b1, 1'b0); check("held_sampled", digit_idx, 1);
    step(1'b0, 1'b0);

    // Both buttons -> BAD; two fails then correct code clears fail_cnt
    step(1'b1, 1'b1); check("both_bad", bad, 1); check("both_idx", digit_idx, 0);
    step(1'b0, 1'b0); check("both_fail1", fail_cnt, 1);
    step(1'b1, 1'b1); step(1'b0, 1'b0); check("both_fail2", fail_cnt, 2);
    enter(4'b1011); check("reopen", unlock, 1); check("fail_clear", fail_cnt, 0);

    // Reset mid-OPENING (timer at 5) and mid-WAIT_REL
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("rst_open_state", state, 0); check("rst_open_flags", {unlock, bad, locked_out}, 0);
    step(1'b1, 1'b0); check("wr_state", state, 1);
    step(1'b1, 1'b0, 1'b1);
    check("rst_wr_state", state, 0); check("rst_wr_idx", digit_idx, 0);
    step(1'b0, 1'b0);

`ifdef NUMLOCK_PROG_EN
    enter(4'b1011); check("p_open", unlock, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1); check("p_state", state, 5); check("p_unlock", unlock, 0);
    enter(4'b0110); check("p_code", code_out, 4'b0110); check("p_done", state, 0);
    step(1'b1, 1'b0); check("p_old_bad", bad, 1);
    step(1'b0, 1'b0);
    enter(4'b0110); check("p_new_open", unlock, 1);
    step(1'b0, 1'b0, 1'b1); check("p_rst_code", code_out, 4'b1011);
    step(1'b0, 1'b0);
`endif

    step(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
